// File: rtl/instruction_arbiter_if.sv
// Producer/consumer bundle for the instruction arbiter:
// per-port move/immediate requests in, one arbitrated stream of each out.
interface instruction_arbiter_if #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
);
   localparam int PORT_WIDTH = $clog2(NUM_PORTS);

   logic [NUM_PORTS*ADDR_WIDTH-1:0] in_move_from;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] in_move_to;
   logic [NUM_PORTS-1:0]            in_move_valid;
   logic [NUM_PORTS-1:0]            in_move_ack;
   logic [NUM_PORTS*ADDR_WIDTH-1:0] in_immediate_addr;
   logic [NUM_PORTS*DATA_WIDTH-1:0] in_immediate;
   logic [NUM_PORTS-1:0]            in_immediate_valid;
   logic [NUM_PORTS-1:0]            in_immediate_ack;

   logic [ADDR_WIDTH-1:0] move_from;
   logic [ADDR_WIDTH-1:0] move_to;
   logic                  move_valid;
   logic                  move_ack;
   logic [ADDR_WIDTH-1:0] immediate_addr;
   logic [DATA_WIDTH-1:0] immediate;
   logic                  immediate_valid;
   logic                  immediate_ack;
   logic [PORT_WIDTH-1:0] move_grant_port;
   logic [PORT_WIDTH-1:0] immediate_grant_port;

   modport slave (
      input  in_move_from, in_move_to, in_move_valid,
      output in_move_ack,
      input  in_immediate_addr, in_immediate, in_immediate_valid,
      output in_immediate_ack,
      output move_from, move_to, move_valid,
      input  move_ack,
      output immediate_addr, immediate, immediate_valid,
      input  immediate_ack,
      output move_grant_port, immediate_grant_port
   );

   modport master (
      output in_move_from, in_move_to, in_move_valid,
      input  in_move_ack,
      output in_immediate_addr, in_immediate, in_immediate_valid,
      input  in_immediate_ack,
      input  move_from, move_to, move_valid,
      output move_ack,
      input  immediate_addr, immediate, immediate_valid,
      output immediate_ack,
      input  move_grant_port, immediate_grant_port
   );
endinterface

// File: rtl/instruction_arbiter.sv
// Round-robin arbitration of move and immediate instructions from
// NUM_PORTS producers onto one consumer, one output register per channel.
module instruction_arbiter_channel #(
   parameter int NUM_PORTS = 4,
   parameter int WIDTH     = 16,
   localparam int IW       = $clog2(NUM_PORTS)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic [NUM_PORTS*WIDTH-1:0] in_data,
   input  logic [NUM_PORTS-1:0]       in_valid,
   output logic [NUM_PORTS-1:0]       in_ack,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ack,
   output logic [IW-1:0]              grant_port
);
   logic [IW-1:0] last_grant;
   logic [IW-1:0] winner;
   logic          found;
   logic          free;
   logic          grant;
   int            idx;

   // Scan from the port after the last winner so every requester gets a turn
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int k = 1; k <= NUM_PORTS; k++) begin
         idx = (int'(last_grant) + k) % NUM_PORTS;
         if (!found && in_valid[idx]) begin
            found  = 1'b1;
            winner = IW'(idx);
         end
      end
   end

   assign free   = !out_valid || out_ack;
   assign grant  = free && enable && found && !reset;
   assign in_ack = grant ? (NUM_PORTS'(1) << winner) : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         grant_port <= '0;
         last_grant <= IW'(NUM_PORTS - 1);
      end else if (grant) begin
         out_valid  <= 1'b1;
         out_data   <= in_data[winner*WIDTH +: WIDTH];
         grant_port <= winner;
         last_grant <= winner;
      end else if (free) begin
         out_valid  <= 1'b0;
      end
   end
endmodule

module instruction_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 32
) (
   input logic                clk,
   input logic                reset,
   input logic                enable,
   instruction_arbiter_if.slave bus
);
   localparam int MW = 2 * ADDR_WIDTH;
   localparam int DW = ADDR_WIDTH + DATA_WIDTH;

   logic [NUM_PORTS*MW-1:0] move_data;
   logic [NUM_PORTS*DW-1:0] imm_data;
   logic [MW-1:0]           move_out;
   logic [DW-1:0]           imm_out;

   always_comb begin
      move_data = '0;
      imm_data  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         move_data[i*MW +: MW] = {bus.in_move_to[i*ADDR_WIDTH +: ADDR_WIDTH],
                                  bus.in_move_from[i*ADDR_WIDTH +: ADDR_WIDTH]};
         imm_data[i*DW +: DW]  = {bus.in_immediate_addr[i*ADDR_WIDTH +: ADDR_WIDTH],
                                  bus.in_immediate[i*DATA_WIDTH +: DATA_WIDTH]};
      end
   end

   instruction_arbiter_channel #(.NUM_PORTS(NUM_PORTS), .WIDTH(MW)) u_move (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .in_data    (move_data),
      .in_valid   (bus.in_move_valid),
      .in_ack     (bus.in_move_ack),
      .out_data   (move_out),
      .out_valid  (bus.move_valid),
      .out_ack    (bus.move_ack),
      .grant_port (bus.move_grant_port)
   );

   instruction_arbiter_channel #(.NUM_PORTS(NUM_PORTS), .WIDTH(DW)) u_imm (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .in_data    (imm_data),
      .in_valid   (bus.in_immediate_valid),
      .in_ack     (bus.in_immediate_ack),
      .out_data   (imm_out),
      .out_valid  (bus.immediate_valid),
      .out_ack    (bus.immediate_ack),
      .grant_port (bus.immediate_grant_port)
   );

   assign {bus.move_to, bus.move_from}         = move_out;
   assign {bus.immediate_addr, bus.immediate}  = imm_out;
endmodule

// File: doc/instruction_arbiter.md
Name: instruction_arbiter

Overview:
- Shares one instruction consumer among NUM_PORTS instruction producers.
- The move channel (from/to) and the immediate channel (addr/data) are arbitrated independently, each by its own round-robin arbiter.
- Each channel has a single registered output stage.
- Sits between the per-unit instruction sources and the single move/immediate consumer port.

Parameters:
- NUM_PORTS, 4, number of producers; must be ≥2.
- ADDR_WIDTH, 8, width of move_from, move_to and immediate_addr.
- DATA_WIDTH, 32, immediate data width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when low, no new grants are issued.
- in_move_from  input  NUM_PORTS*ADDR_WIDTH  per-port move source; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- in_move_to  input  NUM_PORTS*ADDR_WIDTH  per-port move destination.
- in_move_valid  input  NUM_PORTS  per-port move request.
- in_move_ack  output  NUM_PORTS  per-port move accepted.
- in_immediate_addr  input  NUM_PORTS*ADDR_WIDTH  per-port immediate target.
- in_immediate  input  NUM_PORTS*DATA_WIDTH  per-port immediate value.
- in_immediate_valid  input  NUM_PORTS  per-port immediate request.
- in_immediate_ack  output  NUM_PORTS  per-port immediate accepted.
- move_from  output  ADDR_WIDTH  arbitrated move source.
- move_to  output  ADDR_WIDTH  arbitrated move destination.
- move_valid  output  1  move output holds an instruction.
- move_ack  input  1  consumer takes the move.
- immediate_addr  output  ADDR_WIDTH  arbitrated immediate target.
- immediate  output  DATA_WIDTH  arbitrated immediate value.
- immediate_valid  output  1  immediate output holds an instruction.
- immediate_ack  input  1  consumer takes the immediate.
- move_grant_port  output  $clog2(NUM_PORTS)  index of the port whose move is in the output register.
- immediate_grant_port  output  $clog2(NUM_PORTS)  same, for the immediate channel.

Behaviour:
- Handshake, both sides:
  - A transfer occurs in any cycle where valid=1 and ack=1.
  - A producer holds valid and payload stable until acked.
  - Ack is a 1-cycle pulse per transfer.
- Per channel, identical logic; the two channels share nothing except clk, reset and enable.
- The output register is free when out_valid=0, or when out_valid=1 and the consumer ack=1 this cycle.
- Grant condition: register free, enable=1, and at least one in_*_valid bit set.
  - Winner = first valid port scanning last_grant+1, last_grant+2, … modulo NUM_PORTS.
  - In that same cycle, in_*_ack[winner]=1 combinationally; all other in_*_ack bits are 0.
  - On the next edge: payload and winner index latch into the output register, out_valid=1, last_grant=winner.
- When the register is free and no grant is made, out_valid clears on the edge.
- Latency: producer transfer cycle N → output valid at N+1.
- Throughput: 1 instruction/cycle/channel under continuous consumer ack (ack pass-through, no bubble).
- Back-pressure: while out_valid=1 and ack=0, output payload and grant_port stay stable and all in_*_ack stay 0.
- Arbitration is fair: a continuously requesting port waits at most NUM_PORTS-1 grants.
- enable=0 blocks new grants only. A held output is still delivered; out_valid falls after that transfer.
- Consumer ack while out_valid=0 is ignored.
- Reset values:
  - move_valid=0, immediate_valid=0.
  - Output payloads=0, grant_port=0.
  - last_grant=NUM_PORTS-1, so port 0 has first priority.
  - in_*_ack=0 during reset.
- Reset mid-operation: the held instruction is discarded, with no ack to the consumer side. Producers that were not acked keep requesting and are re-arbitrated from port 0.
- No ordering is guaranteed between the move and immediate channels, including for the same port.

Test Plan:
- Port 2 move from=0x03 to=0x05, consumer ack=1 → in_move_ack[2] pulses in cycle N; move_from=0x03, move_to=0x05, move_valid=1, move_grant_port=2 at N+1; immediate channel stays idle.
- All 4 ports hold move valid, consumer ack always 1 → grant order 0,1,2,3,0,1; move_valid continuously 1; each in_move_ack bit pulses once per 4 cycles.
- Port 1 immediate addr=0x10 data=0xDEADBEEF, consumer ack=0 for 5 cycles → output stable at those values, all in_immediate_ack=0 while port 3 requests; on ack, port 3 is granted in that same cycle.
- Port 0 move and port 3 immediate in the same cycle → both acked in that cycle; both outputs valid next cycle with grant ports 0 and 3 respectively.
- Output holding a move, enable=0, ports requesting → held move delivered on ack, then move_valid=0 and no in_move_ack until enable=1.
- Reset asserted while move_valid=1 and 3 ports requesting → next cycle move_valid=0, no acks; after release, port 0 is granted first.
